// File: rtl/pcie_irq_pkg.sv
// Shared constants and state encoding for the PCIe multi-vector interrupt generator.
package pcie_irq_pkg;

    localparam int         C_MSI_FIELD_W = 32;
    localparam logic [3:0] C_LEGACY_INTA = 4'b0001;

    typedef enum logic [8:0] {
        S_IDLE         = 9'b0_0000_0001,
        S_SEND_MSI     = 9'b0_0000_0010,
        S_WAIT_MSI     = 9'b0_0000_0100,
        S_RETRY        = 9'b0_0000_1000,
        S_LEG_ASSERT   = 9'b0_0001_0000,
        S_LEG_HOLD     = 9'b0_0010_0000,
        S_LEG_DEASSERT = 9'b0_0100_0000,
        S_WAIT_RDY_N   = 9'b0_1000_0000,
        S_DONE         = 9'b1_0000_0000
    } state_e;

    // Index width that stays legal for a single-vector build.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcie_irq_rr_arb.sv
// Combinational round-robin picker: lowest requesting index at or after rr_ptr_i, wrapping.
module pcie_irq_rr_arb
    import pcie_irq_pkg::*;
#(
    parameter int C_NUM_VECTORS = 8
) (
    input  logic [C_NUM_VECTORS-1:0]        req_i,
    input  logic [ptr_w(C_NUM_VECTORS)-1:0] rr_ptr_i,
    output logic [ptr_w(C_NUM_VECTORS)-1:0] grant_o,
    output logic                            grant_valid_o
);
    localparam int PTR_W = ptr_w(C_NUM_VECTORS);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int i = 0; i < C_NUM_VECTORS; i++) begin
            idx = PTR_W'((int'(rr_ptr_i) + i) % C_NUM_VECTORS);
            if (!grant_valid_o && req_i[idx]) begin
                grant_o       = idx;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_irq_vec_gen.sv
// Multi-vector interrupt generator: pending/mask tracking, round-robin MSI delivery
// with bounded retry, and shared legacy INTA fallback when MSI is disabled.
module pcie_irq_vec_gen
    import pcie_irq_pkg::*;
#(
    parameter int C_NUM_VECTORS = 8,
    parameter int C_RETRY_DELAY = 16,
    parameter int C_MAX_RETRY   = 3
) (
    input  logic                     pcie_user_clk_i,
    input  logic                     pcie_user_rst_n_i,
    input  logic [C_NUM_VECTORS-1:0] irq_req_i,
    input  logic [C_NUM_VECTORS-1:0] irq_mask_i,
    input  logic                     legacy_irq_clear_i,
    input  logic                     cfg_interrupt_msi_enable_i,
    input  logic                     cfg_interrupt_msi_sent_i,
    input  logic                     cfg_interrupt_msi_fail_i,
    input  logic                     cfg_interrupt_sent_i,
    output logic [C_MSI_FIELD_W-1:0] cfg_interrupt_msi_int_o,
    output logic                     cfg_interrupt_msi_pending_status_data_enable_o,
    output logic [C_MSI_FIELD_W-1:0] cfg_interrupt_msi_pending_status_o,
    output logic                     cfg_interrupt_pending_o,
    output logic [3:0]               cfg_interrupt_int_o,
    output logic [C_NUM_VECTORS-1:0] irq_done_o,
    output logic                     irq_error_o,
    output logic                     irq_busy_o
);
    localparam int PTR_W = ptr_w(C_NUM_VECTORS);
    localparam int RTY_W = $clog2(C_MAX_RETRY + 1);
    localparam int DLY_W = $clog2(C_RETRY_DELAY + 1);

    state_e                   state_q, state_d;
    logic [C_NUM_VECTORS-1:0] pend_q, pend_d, leg_set_q, leg_set_d, clr;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d, grant_q, grant_d, arb_grant;
    logic                     arb_valid;
    logic [RTY_W-1:0]         retry_q, retry_d;
    logic [DLY_W-1:0]         dly_q, dly_d;
    logic                     is_leg_q, is_leg_d, err_q, err_d;
    logic [C_NUM_VECTORS-1:0] eligible, grant_onehot;

    assign eligible     = pend_q & ~irq_mask_i;
    assign grant_onehot = C_NUM_VECTORS'(1) << grant_q;
    // A new request outranks a same-cycle clear so no event is lost.
    assign pend_d       = (pend_q & ~clr) | irq_req_i;

    pcie_irq_rr_arb #(
        .C_NUM_VECTORS(C_NUM_VECTORS)
    ) u_arb (
        .req_i        (eligible),
        .rr_ptr_i     (rr_ptr_q),
        .grant_o      (arb_grant),
        .grant_valid_o(arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        leg_set_d = leg_set_q;
        retry_d   = retry_q;
        dly_d     = dly_q;
        is_leg_d  = is_leg_q;
        err_d     = err_q;
        clr       = '0;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (cfg_interrupt_msi_enable_i && arb_valid) begin
                    grant_d  = arb_grant;
                    rr_ptr_d = (arb_grant == PTR_W'(C_NUM_VECTORS - 1)) ? '0 : arb_grant + 1'b1;
                    is_leg_d = 1'b0;
                    state_d  = S_SEND_MSI;
                end else if (!cfg_interrupt_msi_enable_i && arb_valid) begin
                    leg_set_d = eligible;
                    is_leg_d  = 1'b1;
                    state_d   = S_LEG_ASSERT;
                end
            end
            S_SEND_MSI: state_d = S_WAIT_MSI;
            S_WAIT_MSI: begin
                if (cfg_interrupt_msi_sent_i) begin
                    clr     = grant_onehot;
                    retry_d = '0;
                    state_d = S_WAIT_RDY_N;
                end else if (cfg_interrupt_msi_fail_i) begin
                    if (retry_q == RTY_W'(C_MAX_RETRY - 1)) begin
                        clr     = grant_onehot;
                        retry_d = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        dly_d   = DLY_W'(C_RETRY_DELAY - 1);
                        state_d = S_RETRY;
                    end
                end
            end
            S_RETRY: begin
                if (dly_q == '0) state_d = S_IDLE;
                else             dly_d   = dly_q - 1'b1;
            end
            S_LEG_ASSERT:   if (cfg_interrupt_sent_i) state_d = S_LEG_HOLD;
            S_LEG_HOLD:     if (legacy_irq_clear_i)   state_d = S_LEG_DEASSERT;
            S_LEG_DEASSERT: begin
                if (cfg_interrupt_sent_i) begin
                    clr     = leg_set_q;
                    state_d = S_WAIT_RDY_N;
                end
            end
            S_WAIT_RDY_N: begin
                if (!cfg_interrupt_sent_i && !cfg_interrupt_msi_sent_i) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_interrupt_msi_int_o                        = '0;
        cfg_interrupt_msi_pending_status_data_enable_o = 1'b0;
        cfg_interrupt_pending_o                        = 1'b0;
        cfg_interrupt_int_o                            = 4'b0000;
        irq_done_o                                     = '0;
        irq_error_o                                    = 1'b0;
        irq_busy_o                                     = (state_q != S_IDLE);
        cfg_interrupt_msi_pending_status_o             = C_MSI_FIELD_W'(pend_q);
        if (state_q == S_SEND_MSI) begin
            cfg_interrupt_msi_int_o = C_MSI_FIELD_W'(grant_onehot);
        end
        if (state_q == S_SEND_MSI || state_q == S_WAIT_MSI) begin
            cfg_interrupt_msi_pending_status_data_enable_o = 1'b1;
        end
        if (state_q == S_LEG_ASSERT || state_q == S_LEG_HOLD) begin
            cfg_interrupt_pending_o = 1'b1;
            cfg_interrupt_int_o     = C_LEGACY_INTA;
        end
        if (state_q == S_DONE) begin
            irq_done_o  = is_leg_q ? leg_set_q : grant_onehot;
            irq_error_o = err_q;
        end
    end

    always_ff @(posedge pcie_user_clk_i or negedge pcie_user_rst_n_i) begin
        if (!pcie_user_rst_n_i) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            leg_set_q <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            retry_q   <= '0;
            dly_q     <= '0;
            is_leg_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            leg_set_q <= leg_set_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            retry_q   <= retry_d;
            dly_q     <= dly_d;
            is_leg_q  <= is_leg_d;
            err_q     <= err_d;
        end
    end

endmodule
